// File: rtl/uart_fmt_pkg.sv
// Shared encodings and constants for the UART hex line formatter.
package uart_fmt_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned CNT_W   = 3;

   // Line formatter states
   localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
   localparam logic [STATE_W-1:0] ST_HEX0 = 3'd1;
   localparam logic [STATE_W-1:0] ST_SEP  = 3'd2;
   localparam logic [STATE_W-1:0] ST_HEX1 = 3'd3;
   localparam logic [STATE_W-1:0] ST_CR   = 3'd4;
   localparam logic [STATE_W-1:0] ST_LF   = 3'd5;
   localparam logic [STATE_W-1:0] ST_DONE = 3'd6;

   // ASCII constants
   localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
   localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;
   localparam logic [BYTE_W-1:0] ASCII_0  = 8'h30;
   localparam logic [BYTE_W-1:0] ASCII_A  = 8'h61;

   // Last digit index of an 8-digit word
   localparam logic [CNT_W-1:0] LAST_DIGIT = 3'd7;

endpackage

// File: rtl/uart_rdata_sender_hex_nibble_ascii.sv
// Combinational nibble to lowercase ASCII hex digit converter.
module hex_nibble_ascii
   import uart_fmt_pkg::*;
(
   input  logic [NIB_W-1:0]  nibble,
   output logic [BYTE_W-1:0] ascii_c
);

   // 0-9 map onto '0'..'9', 10-15 onto 'a'..'f'
   always_comb begin
      ascii_c = ASCII_0 + BYTE_W'(nibble);
      if (nibble > 4'd9) begin
         ascii_c = ASCII_A + BYTE_W'(nibble) - 8'd10;
      end
   end

endmodule

// File: rtl/uart_rdata_sender.sv
// Formats a captured 32/64-bit monitor payload as an ASCII hex line and
// streams it to the UART transmitter over a valid/ready handshake.
module uart_rdata_sender
   import uart_fmt_pkg::*;
#(
   parameter logic [7:0] SEP_CHAR = 8'h20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdata_snd_start,
   input  logic [DATA_W-1:0] rdata_snd,
   input  logic              pc_print_sel,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              flushing_wq,
   output logic              snd_busy
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [WORD_W-1:0]  shift_q, shift_d;
   logic [WORD_W-1:0]  word1_q, word1_d;
   logic               pc_mode_q, pc_mode_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               flush_q, flush_d;
   logic               busy_q, busy_d;
   logic               accept;
   logic [BYTE_W-1:0]  digit_ascii;

   assign accept = tx_valid_q & tx_ready;

   // Leading nibble of the next shift-register value is the next digit shown
   hex_nibble_ascii u_hex (
      .nibble  (shift_d[WORD_W-1 -: NIB_W]),
      .ascii_c (digit_ascii)
   );

   // Next-state, datapath and next-output computation
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      word1_d    = word1_q;
      pc_mode_d  = pc_mode_q;
      cnt_d      = cnt_q;
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
      flush_d    = 1'b0;
      busy_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rdata_snd_start) begin
               shift_d   = rdata_snd[WORD_W-1:0];
               word1_d   = rdata_snd[DATA_W-1:WORD_W];
               pc_mode_d = pc_print_sel;
               cnt_d     = '0;
               state_d   = ST_HEX0;
            end
         end
         ST_HEX0: begin
            if (accept) begin
               shift_d = shift_q << NIB_W;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_DIGIT) begin
                  state_d = pc_mode_q ? ST_CR : ST_SEP;
               end
            end
         end
         ST_SEP: begin
            if (accept) begin
               shift_d = word1_q;
               cnt_d   = '0;
               state_d = ST_HEX1;
            end
         end
         ST_HEX1: begin
            if (accept) begin
               shift_d = shift_q << NIB_W;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_DIGIT) begin
                  state_d = ST_CR;
               end
            end
         end
         ST_CR: begin
            if (accept) begin
               state_d = ST_LF;
            end
         end
         ST_LF: begin
            if (accept) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_HEX0, ST_HEX1: begin
            tx_valid_d = 1'b1;
            tx_data_d  = digit_ascii;
         end
         ST_SEP: begin
            tx_valid_d = 1'b1;
            tx_data_d  = SEP_CHAR;
         end
         ST_CR: begin
            tx_valid_d = 1'b1;
            tx_data_d  = ASCII_CR;
         end
         ST_LF: begin
            tx_valid_d = 1'b1;
            tx_data_d  = ASCII_LF;
         end
         default: begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end
      endcase

      flush_d = (state_d == ST_DONE);
      busy_d  = (state_d != ST_IDLE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         word1_q    <= '0;
         pc_mode_q  <= 1'b0;
         cnt_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         flush_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         word1_q    <= word1_d;
         pc_mode_q  <= pc_mode_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         flush_q    <= flush_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign flushing_wq = flush_q;
   assign snd_busy    = busy_q;

endmodule

// File: doc/uart_rdata_sender.md
# uart_rdata_sender

Consumes the send request issued by the UART monitor logic (`rdata_snd_start`, `rdata_snd`, `pc_print_sel`). Formats the captured data as an ASCII hex line and feeds it byte-by-byte to the UART transmitter over a valid/ready handshake. Pulses `flushing_wq` once the final byte is accepted, which releases the monitor's dump state machine from its wait state. Sits between the monitor logic and the UART TX serializer.

## Interface
- `SEP_CHAR`, default 8'h20 — separator byte between the two words in 64-bit mode.
- `clk`  in  1  — system clock; all logic on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `rdata_snd_start`  in  1  — single-cycle request to send one line.
- `rdata_snd`  in  64  — payload; [31:0] = word0, [63:32] = word1.
- `pc_print_sel`  in  1  — 1 selects 32-bit mode (PC print, word0 only); 0 selects 64-bit mode.
- `tx_data`  out  8  — ASCII byte to the transmitter.
- `tx_valid`  out  1  — `tx_data` is valid.
- `tx_ready`  in  1  — transmitter accepts the byte this cycle.
- `flushing_wq`  out  1  — one-cycle pulse: line fully handed off.
- `snd_busy`  out  1  — high from the cycle after a start is accepted until the `flushing_wq` cycle, inclusive.

## Operation
- **Capture.** In IDLE, `rdata_snd_start`=1 latches `rdata_snd` and `pc_print_sel` into internal registers. Later changes on these inputs are ignored until the line completes.
- **Start while busy.** `rdata_snd_start` is ignored in any state other than IDLE, including the DONE cycle. It is neither queued nor counted.
- **64-bit line (19 bytes):**
  - word0 as 8 hex digits, MSB nibble first.
  - `SEP_CHAR`.
  - word1 as 8 hex digits, MSB nibble first.
  - 8'h0D, 8'h0A.
- **32-bit line (10 bytes):** word0 as 8 hex digits, then 8'h0D, 8'h0A.
- **Hex encoding:** nibble 0–9 maps to 8'h30+n; nibble 10–15 maps to 8'h61+(n−10), i.e. lowercase 'a'–'f'.
- **State machine:**
  - IDLE → HEX0 on start.
  - HEX0 → SEP after 8 digits in 64-bit mode; → CR after 8 digits in 32-bit mode.
  - SEP → HEX1.
  - HEX1 → CR after 8 digits.
  - CR → LF.
  - LF → DONE.
  - DONE → IDLE unconditionally after one cycle.
- **Advance rule.** A state or digit advances only on a cycle where `tx_valid & tx_ready`.
- **Digit handling.** A 3-bit digit counter wraps 7→0 on the eighth accepted digit. A 32-bit shift register shifts left 4 bits per accepted digit. Entry to HEX1 reloads it with word1.
- **Handshake.** `tx_valid` is high in HEX0, SEP, HEX1, CR and LF. While `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable. `tx_valid` never drops without acceptance.
- **Completion.** `flushing_wq` is high only in DONE.
- **Reset values:**
  - `tx_valid`=0, `tx_data`=8'h00, `flushing_wq`=0, `snd_busy`=0.
  - State = IDLE; captured data and counters cleared.
- **Reset mid-line.** The line is aborted: no further bytes and no `flushing_wq` pulse. The state returns to IDLE on the next edge.

## Timing
- Start sampled at edge T. First byte is valid from T+1, with `tx_valid`=1 and `snd_busy`=1.
- With `tx_ready` tied high:
  - 64-bit line: bytes at T+1..T+19, `flushing_wq` at T+20.
  - 32-bit line: bytes at T+1..T+10, `flushing_wq` at T+11.
- Each cycle of `tx_ready`=0 adds exactly one cycle of latency.
- Earliest accepted restart: the cycle after DONE, i.e. IDLE at T+21 in 64-bit mode. First byte of the next line follows one cycle later.
- `tx_data`, `tx_valid` and `flushing_wq` are registered outputs. `tx_ready` has no combinational path to any output.

## Structure
- **Package `uart_fmt_pkg`:**
  - State encoding: IDLE, HEX0, SEP, HEX1, CR, LF, DONE (3 bits).
  - Constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A=8'h61.
- **Sub-module `hex_nibble_ascii`:** combinational 4-bit → 8-bit ASCII converter, instantiated once on shift-register bits [31:28].

## Test plan
- **64-bit, `tx_ready`=1.** Start with `rdata_snd`=64'h89ABCDEF_01234567, `pc_print_sel`=0. Expected: "01234567 89abcdef\r\n" (19 bytes, T+1..T+19), `flushing_wq` single pulse at T+20.
- **PC mode.** `pc_print_sel`=1, `rdata_snd`=64'hFFFF_FFFF_0000_1A2C. Expected: "00001a2c\r\n" (10 bytes), `flushing_wq` at T+11; upper word never emitted.
- **Backpressure.** 64-bit line with `tx_ready` low on every other cycle. Expected: identical 19-byte sequence, `tx_data` stable during stalls, `flushing_wq` at T+38.
- **Start while busy.** Second `rdata_snd_start` with different data at T+5 and in the DONE cycle. Expected: both ignored, one line from the first payload, exactly one `flushing_wq` pulse.
- **Reset mid-line.** `rst` asserted after the 4th byte accepted. Expected: next cycle `tx_valid`=0, `snd_busy`=0, no `flushing_wq`. A new start then yields the full line from its first digit.
